// File: rtl/melody_player.sv
// melody_player: plays one of four stored 5-note melodies as timed (nota, tom) symbols with ok/fim strobes
module melody_player #(
  parameter int NOTE_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo,
  input  logic       abort,
  input  logic       hold,
  output logic [2:0] nota,
  output logic       tom,
  output logic       ok,
  output logic       fim,
  output logic       busy
);
  localparam int TMAX = NOTE_CYCLES > GAP_CYCLES ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, NOTE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d, nota_q, nota_d;
  logic [1:0] tipo_q, tipo_d;
  logic tom_q, tom_d, ok_q, ok_d, fim_q, fim_d, busy_q, busy_d;
  logic [3:0] first_note, next_note;
  // each row packs five 3-bit notes, index 0 in the low bits; only tipo 3 uses sharps
  function automatic logic [3:0] rom(input logic [1:0] t, input logic [2:0] i);
    logic [14:0] r;
    r = t == 2'd0 ? 15'b000_010_100_010_000 :
        t == 2'd1 ? 15'b000_100_101_100_100 :
        t == 2'd2 ? 15'b010_011_100_101_110 : 15'b110_101_011_001_000;
    return {t == 2'd3 && (i == 3'd1 || i == 3'd3), r[3*i +: 3]};
  endfunction
  assign first_note = rom(tipo, 3'd0);
  assign next_note  = rom(tipo_q, idx_q + 3'd1);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    tipo_d  = tipo_q;
    nota_d  = nota_q;
    tom_d   = tom_q;
    ok_d    = 1'b0;
    fim_d   = 1'b0;
    busy_d  = busy_q;
    if (abort) begin
      state_d = IDLE;
      timer_d = '0;
      idx_d   = '0;
      nota_d  = 3'd7;
      tom_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (!hold) begin
      case (state_q)
        IDLE: if (start) begin
          state_d = NOTE;
          tipo_d  = tipo;
          timer_d = TW'(1);
          idx_d   = '0;
          {tom_d, nota_d} = first_note;
          ok_d    = 1'b1;
          busy_d  = 1'b1;
        end
        NOTE: if (timer_q < TW'(NOTE_CYCLES)) timer_d = timer_q + TW'(1);
        else if (idx_q == 3'd4) begin
          state_d = DONE;
          nota_d  = 3'd7;
          tom_d   = 1'b0;
          fim_d   = 1'b1;
        end else if (GAP_CYCLES == 0) begin
          idx_d   = idx_q + 3'd1;
          timer_d = TW'(1);
          {tom_d, nota_d} = next_note;
          ok_d    = 1'b1;
        end else begin
          state_d = GAP;
          timer_d = TW'(1);
          nota_d  = 3'd7;
          tom_d   = 1'b0;
        end
        GAP: if (timer_q < TW'(GAP_CYCLES)) timer_d = timer_q + TW'(1);
        else begin
          state_d = NOTE;
          idx_d   = idx_q + 3'd1;
          timer_d = TW'(1);
          {tom_d, nota_d} = next_note;
          ok_d    = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          timer_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      tipo_q  <= '0;
      nota_q  <= 3'd7;
      tom_q   <= 1'b0;
      ok_q    <= 1'b0;
      fim_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tipo_q  <= tipo_d;
      nota_q  <= nota_d;
      tom_q   <= tom_d;
      ok_q    <= ok_d;
      fim_q   <= fim_d;
      busy_q  <= busy_d;
    end
  end
  assign nota = nota_q;
  assign tom  = tom_q;
  assign ok   = ok_q;
  assign fim  = fim_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed checks of melody_player with GAP_CYCLES=1 and GAP_CYCLES=0 side by side
module tb_melody_player;
  logic clk = 1'b0, reset, start, abort, hold;
  logic [1:0] tipo;
  logic [2:0] nota_g1, nota_g0;
  logic tom_g1, ok_g1, fim_g1, busy_g1, tom_g0, ok_g0, fim_g0, busy_g0;
  int checks = 0, errors = 0;
  logic [2:0] mel [4][5] = '{'{0, 2, 4, 2, 0}, '{4, 4, 5, 4, 0}, '{6, 5, 4, 3, 2}, '{0, 1, 3, 5, 6}};
  melody_player #(.NOTE_CYCLES(4), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .reset(reset), .start(start), .tipo(tipo), .abort(abort), .hold(hold),
    .nota(nota_g1), .tom(tom_g1), .ok(ok_g1), .fim(fim_g1), .busy(busy_g1));
  melody_player #(.NOTE_CYCLES(4), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .reset(reset), .start(start), .tipo(tipo), .abort(abort), .hold(hold),
    .nota(nota_g0), .tom(tom_g0), .ok(ok_g0), .fim(fim_g0), .busy(busy_g0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s {nota,tom,ok,fim,busy} got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // reference timing: note n starts at cycle 1+n*(4+g); done cycle is 21+4g; hold freezes 3 cycles after hold_at
  function automatic logic [6:0] model(input int g, input int tp, input int c, input int hold_at, input int stop);
    int ce, p, last, seg, pos;
    logic [2:0] n;
    logic t, o, f, b;
    bit frz;
    n = 3'd7; t = 0; o = 0; f = 0; b = 0;
    if (c > stop) return {3'd7, 4'b0000};
    frz = hold_at > 0 && c > hold_at && c <= hold_at + 3;
    ce = (hold_at == 0 || c <= hold_at) ? c : frz ? hold_at : c - 3;
    p = 4 + g;
    last = 20 + 4 * g;
    if (ce <= last) begin
      b = 1;
      seg = (ce - 1) / p;
      pos = (ce - 1) % p;
      if (pos < 4) begin
        n = mel[tp][seg];
        t = tp == 3 && (seg == 1 || seg == 3);
        o = pos == 0 && !frz;
      end
    end else if (ce == last + 1) begin
      b = 1;
      f = !frz;
    end
    return {n, t, o, f, b};
  endfunction
  task automatic run(input int tp, input int hold_at, input int abort_at, input int rst_at,
                     input int start_at, input int ncyc);
    int stop;
    stop = abort_at > 0 ? abort_at : rst_at > 0 ? rst_at : 1000;
    tipo = 2'(tp);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("t%0d g1 c%0d", tp, c), {nota_g1, tom_g1, ok_g1, fim_g1, busy_g1}, model(1, tp, c, hold_at, stop));
      chk($sformatf("t%0d g0 c%0d", tp, c), {nota_g0, tom_g0, ok_g0, fim_g0, busy_g0}, model(0, tp, c, hold_at, stop));
      hold  = hold_at > 0 && c >= hold_at && c < hold_at + 3;
      abort = c == abort_at;
      reset = c == rst_at;
      start = start_at > 0 && (c == start_at || c == start_at + 4);
      tipo  = start ? ~2'(tp) : 2'(tp);
      step();
    end
    {hold, abort, reset, start} = 4'b0000;
  endtask
  initial begin
    {reset, start, abort, hold, tipo} = 6'b100000;
    step();
    step();
    chk("reset g1", {nota_g1, tom_g1, ok_g1, fim_g1, busy_g1}, 7'b111_0000);
    chk("reset g0", {nota_g0, tom_g0, ok_g0, fim_g0, busy_g0}, 7'b111_0000);
    reset = 1'b0;
    step();
    run(0, 0, 0, 0, 0, 27);
    run(3, 0, 0, 0, 0, 27);
    run(1, 0, 8, 0, 0, 12);
    run(1, 0, 0, 0, 0, 27);
    run(2, 12, 0, 0, 0, 30);
    run(2, 0, 0, 10, 3, 14);
    start = 1'b1;
    abort = 1'b1;
    step();
    chk("start+abort g1", {nota_g1, tom_g1, ok_g1, fim_g1, busy_g1}, 7'b111_0000);
    chk("start+abort g0", {nota_g0, tom_g0, ok_g0, fim_g0, busy_g0}, 7'b111_0000);
    {start, abort} = 2'b00;
    step();
    chk("after abort g1", {nota_g1, tom_g1, ok_g1, fim_g1, busy_g1}, 7'b111_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
